// File: rtl/subleq_pkg.sv
// Shared types and constants for the SUBLEQ memory responder and control unit.
// Holds the FSM state type, request-decode encodings and default bus widths.
package subleq_pkg;

  localparam int unsigned DEF_ADR_W = 8;
  localparam int unsigned DEF_DAT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_WR      = 3'd2,
    ST_RESP    = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    REQ_IDLE    = 2'd0,
    REQ_READ    = 2'd1,
    REQ_WRITE   = 2'd2,
    REQ_ILLEGAL = 2'd3
  } req_e;

  // ram_ope / ram_ctl are active-low strobes qualified by ram_ena.
  function automatic req_e decode_req(input logic ena, input logic ope, input logic ctl);
    req_e r;
    r = REQ_IDLE;
    if (ena) begin
      if (!ope && ctl)       r = REQ_READ;
      else if (ope && !ctl)  r = REQ_WRITE;
      else if (!ope && !ctl) r = REQ_ILLEGAL;
    end
    return r;
  endfunction

endpackage

// File: rtl/subleq_ram_array.sv
// Word-addressed storage: synchronous write through one muxed port, registered read.
// Contents are intentionally not reset.
module subleq_ram_array #(
  parameter int unsigned ADR_W = 8,
  parameter int unsigned DAT_W = 8
) (
  input  logic             clk,
  input  logic             acc_we,
  input  logic [ADR_W-1:0] acc_adr,
  input  logic [DAT_W-1:0] acc_dat,
  input  logic             ld_we,
  input  logic [ADR_W-1:0] ld_adr,
  input  logic [DAT_W-1:0] ld_dat,
  input  logic [ADR_W-1:0] rd_adr,
  output logic [DAT_W-1:0] rd_dat
);

  localparam int unsigned DEPTH = 2 ** ADR_W;

  logic [DAT_W-1:0] mem [DEPTH];
  logic [DAT_W-1:0] rd_dat_q;
  logic             we_c;
  logic [ADR_W-1:0] wadr_c;
  logic [DAT_W-1:0] wdat_c;

  // Access and loader never write in the same cycle; access wins regardless.
  always_comb begin
    we_c   = acc_we | ld_we;
    wadr_c = acc_we ? acc_adr : ld_adr;
    wdat_c = acc_we ? acc_dat : ld_dat;
  end

  always_ff @(posedge clk) begin
    if (we_c) mem[wadr_c] <= wdat_c;
    rd_dat_q <= mem[rd_adr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/subleq_mem_responder.sv
// Handshaked memory responder: decodes ram_ena/ram_ope/ram_ctl, runs one access per
// request with programmable read latency, and holds until the request is released.
module subleq_mem_responder
  import subleq_pkg::*;
#(
  parameter int unsigned ADR_W  = DEF_ADR_W,
  parameter int unsigned DAT_W  = DEF_DAT_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             ram_ena,
  input  logic             ram_ope,
  input  logic             ram_ctl,
  input  logic [ADR_W-1:0] adr,
  input  logic [DAT_W-1:0] dat_in,
  input  logic             ld_we,
  input  logic [ADR_W-1:0] ld_adr,
  input  logic [DAT_W-1:0] ld_dat,
  output logic [DAT_W-1:0] dat_out,
  output logic             dat_oe,
  output logic             ram_rdy,
  output logic             ram_busy,
  output logic             ram_err
);

  localparam int unsigned CNT_W = 3;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] wdat_q, wdat_d;
  logic             rd_q, rd_d;
  logic [DAT_W-1:0] dout_q, dout_d;
  logic             oe_q, oe_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  req_e             req_c;
  logic             ld_en_c;
  logic             acc_we_c;
  logic [ADR_W-1:0] rd_adr_c;
  logic [DAT_W-1:0] rd_dat_c;

  // The read port follows the live address in IDLE so the accept edge already fetches.
  always_comb begin
    req_c    = decode_req(ram_ena, ram_ope, ram_ctl);
    ld_en_c  = ld_we && (state_q == ST_IDLE);
    acc_we_c = (state_q == ST_WR);
    rd_adr_c = (state_q == ST_IDLE) ? adr : adr_q;
  end

  subleq_ram_array #(
    .ADR_W (ADR_W),
    .DAT_W (DAT_W)
  ) u_ram (
    .clk     (clk),
    .acc_we  (acc_we_c),
    .acc_adr (adr_q),
    .acc_dat (wdat_q),
    .ld_we   (ld_en_c),
    .ld_adr  (ld_adr),
    .ld_dat  (ld_dat),
    .rd_adr  (rd_adr_c),
    .rd_dat  (rd_dat_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rd_q    <= 1'b0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rd_q    <= rd_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; the loader pre-empts acceptance of a request in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rd_d    = rd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!ld_en_c) begin
          unique case (req_c)
            REQ_READ: begin
              state_d = ST_RD_WAIT;
              adr_d   = adr;
              wdat_d  = dat_in;
              rd_d    = 1'b1;
              cnt_d   = '0;
            end
            REQ_WRITE: begin
              state_d = ST_WR;
              adr_d   = adr;
              wdat_d  = dat_in;
              rd_d    = 1'b0;
            end
            REQ_ILLEGAL: begin
              state_d = ST_HOLD;
              rd_d    = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_HOLD;
      ST_HOLD: if (req_c == REQ_IDLE) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values, derived from the upcoming state.
  always_comb begin
    rdy_d  = (state_d == ST_RESP);
    busy_d = (state_d != ST_IDLE);
    oe_d   = rd_d && ((state_d == ST_RESP) || (state_d == ST_HOLD));
    err_d  = (state_q == ST_IDLE) && !ld_en_c && (req_c == REQ_ILLEGAL);
    dout_d = ((state_q == ST_RD_WAIT) && (state_d == ST_RESP)) ? rd_dat_c : dout_q;
  end

  assign dat_out  = dout_q;
  assign dat_oe   = oe_q;
  assign ram_rdy  = rdy_q;
  assign ram_busy = busy_q;
  assign ram_err  = err_q;

endmodule

// File: tb/tb_subleq_mem_responder.sv
// Directed bench: two responders (RD_LAT=1 and RD_LAT=3) share stimulus; a vector
// table drives the main checks and hand sequences cover latency and reset corners.
module tb_subleq_mem_responder;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       ram_ena = 1'b0, ram_ope = 1'b1, ram_ctl = 1'b1;
  logic [7:0] adr = '0, dat_in = '0;
  logic       ld_we = 1'b0;
  logic [7:0] ld_adr = '0, ld_dat = '0;

  logic [7:0] d1_dout, d3_dout;
  logic       d1_oe, d1_rdy, d1_busy, d1_err;
  logic       d3_oe, d3_rdy, d3_busy, d3_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  subleq_mem_responder #(.ADR_W(8), .DAT_W(8), .RD_LAT(1)) dut1 (
    .clk(clk), .res(res), .ram_ena(ram_ena), .ram_ope(ram_ope), .ram_ctl(ram_ctl),
    .adr(adr), .dat_in(dat_in), .ld_we(ld_we), .ld_adr(ld_adr), .ld_dat(ld_dat),
    .dat_out(d1_dout), .dat_oe(d1_oe), .ram_rdy(d1_rdy), .ram_busy(d1_busy), .ram_err(d1_err)
  );

  subleq_mem_responder #(.ADR_W(8), .DAT_W(8), .RD_LAT(3)) dut3 (
    .clk(clk), .res(res), .ram_ena(ram_ena), .ram_ope(ram_ope), .ram_ctl(ram_ctl),
    .adr(adr), .dat_in(dat_in), .ld_we(ld_we), .ld_adr(ld_adr), .ld_dat(ld_dat),
    .dat_out(d3_dout), .dat_oe(d3_oe), .ram_rdy(d3_rdy), .ram_busy(d3_busy), .ram_err(d3_err)
  );

  // flags = {rdy, oe, busy, err}
  typedef struct {
    logic       ena, ope, ctl;
    logic [7:0] a, d;
    logic       lw;
    logic [7:0] la, ldd;
    logic [3:0] flags;
    logic [7:0] dout;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic ena, input logic ope, input logic ctl,
                     input logic [7:0] a, input logic [7:0] d,
                     input logic lw, input logic [7:0] la, input logic [7:0] ldd,
                     input logic [3:0] flags, input logic [7:0] dout);
    vec_t v;
    v.ena = ena; v.ope = ope; v.ctl = ctl; v.a = a; v.d = d;
    v.lw = lw; v.la = la; v.ldd = ldd; v.flags = flags; v.dout = dout;
    vq.push_back(v);
  endtask

  task automatic idl(input logic [3:0] f, input logic [7:0] o);
    add(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, f, o);
  endtask
  task automatic rd(input logic [7:0] a, input logic [3:0] f, input logic [7:0] o);
    add(1'b1, 1'b0, 1'b1, a, 8'h00, 1'b0, 8'h00, 8'h00, f, o);
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic [3:0] f, input logic [7:0] o);
    add(1'b1, 1'b1, 1'b0, a, d, 1'b0, 8'h00, 8'h00, f, o);
  endtask
  task automatic ld(input logic [7:0] a, input logic [7:0] d, input logic [3:0] f, input logic [7:0] o);
    add(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, a, d, f, o);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ena, input logic ope, input logic ctl,
                       input logic [7:0] a, input logic [7:0] d);
    ram_ena = ena; ram_ope = ope; ram_ctl = ctl; adr = a; dat_in = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rdy_cnt;
    // Async reset with no clock edge involved.
    #2 res = 1'b0;
    #1;
    chk("reset_flags", {d1_rdy, d1_oe, d1_busy, d1_err}, 4'b0000);
    chk("reset_dout", d1_dout, 8'h00);
    #9 res = 1'b1;

    ld(8'h10, 8'hA5, 4'b0000, 8'h00);
    ld(8'h30, 8'h55, 4'b0000, 8'h00);
    ld(8'h11, 8'h22, 4'b0000, 8'h00);
    rd(8'h10, 4'b0010, 8'h00);
    idl(4'b1110, 8'hA5);
    idl(4'b0110, 8'hA5);
    idl(4'b0000, 8'hA5);
    idl(4'b0000, 8'hA5);
    idl(4'b0000, 8'hA5);
    // Level-held write for six cycles: one rdy, busy until release.
    wr(8'h20, 8'h3C, 4'b0010, 8'hA5);
    wr(8'h20, 8'h3C, 4'b1010, 8'hA5);
    for (int i = 0; i < 4; i++) wr(8'h20, 8'h3C, 4'b0010, 8'hA5);
    idl(4'b0000, 8'hA5);
    rd(8'h20, 4'b0010, 8'hA5);
    idl(4'b1110, 8'h3C);
    idl(4'b0110, 8'h3C);
    idl(4'b0000, 8'h3C);
    idl(4'b0000, 8'h3C);
    idl(4'b0000, 8'h3C);
    // Illegal decode.
    add(1'b1, 1'b0, 1'b0, 8'h10, 8'hEE, 1'b0, 8'h00, 8'h00, 4'b0011, 8'h3C);
    idl(4'b0000, 8'h3C);
    rd(8'h10, 4'b0010, 8'h3C);
    idl(4'b1110, 8'hA5);
    idl(4'b0110, 8'hA5);
    idl(4'b0000, 8'hA5);
    idl(4'b0000, 8'hA5);
    idl(4'b0000, 8'hA5);
    // Loader collides with a read on the same edge.
    add(1'b1, 1'b0, 1'b1, 8'h40, 8'h00, 1'b1, 8'h40, 8'h11, 4'b0000, 8'hA5);
    rd(8'h40, 4'b0010, 8'hA5);
    idl(4'b1110, 8'h11);
    idl(4'b0110, 8'h11);
    idl(4'b0000, 8'h11);
    idl(4'b0000, 8'h11);
    idl(4'b0000, 8'h11);
    // Loader strobe during WR must be ignored.
    wr(8'h50, 8'h77, 4'b0010, 8'h11);
    ld(8'h10, 8'h99, 4'b1010, 8'h11);
    idl(4'b0010, 8'h11);
    idl(4'b0000, 8'h11);
    rd(8'h50, 4'b0010, 8'h11);
    idl(4'b1110, 8'h77);
    idl(4'b0110, 8'h77);
    idl(4'b0000, 8'h77);
    idl(4'b0000, 8'h77);
    idl(4'b0000, 8'h77);
    rd(8'h10, 4'b0010, 8'h77);
    idl(4'b1110, 8'hA5);
    idl(4'b0110, 8'hA5);
    idl(4'b0000, 8'hA5);
    idl(4'b0000, 8'hA5);
    idl(4'b0000, 8'hA5);

    foreach (vq[i]) begin
      drive(vq[i].ena, vq[i].ope, vq[i].ctl, vq[i].a, vq[i].d);
      ld_we = vq[i].lw; ld_adr = vq[i].la; ld_dat = vq[i].ldd;
      @(posedge clk); #1;
      chk($sformatf("row%0d_flags", i), {d1_rdy, d1_oe, d1_busy, d1_err}, vq[i].flags);
      chk($sformatf("row%0d_dout", i), d1_dout, vq[i].dout);
    end
    ld_we = 1'b0;

    // RD_LAT=3: rdy exactly three edges after accept; address change is ignored.
    drive(1'b1, 1'b0, 1'b1, 8'h10, 8'h00);
    @(posedge clk); #1;
    chk("lat3_accept_busy", d3_busy, 1'b1);
    adr = 8'h11;
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk); #1;
      chk($sformatf("lat3_rdy_k%0d", j), d3_rdy, (j == 3) ? 1'b1 : 1'b0);
      if (j == 1) chk("lat1_dout_in_lat3_seq", d1_dout, 8'hA5);
      if (j == 3) begin
        chk("lat3_dout", d3_dout, 8'hA5);
        chk("lat3_oe", d3_oe, 1'b1);
      end
    end
    drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    @(posedge clk); #1;
    chk("lat3_release_busy", {d1_busy, d3_busy}, 2'b00);

    // Level-held read on the RD_LAT=1 part: exactly one rdy pulse.
    rdy_cnt = 0;
    drive(1'b1, 1'b0, 1'b1, 8'h20, 8'h00);
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      if (d1_rdy) rdy_cnt++;
    end
    chk("held_read_rdy_count", rdy_cnt, 1);
    chk("held_read_busy", d1_busy, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;

    // Reset while a write is pending: write dropped, outputs cleared at once.
    drive(1'b1, 1'b1, 1'b0, 8'h30, 8'hFF);
    @(posedge clk); #1;
    chk("rst_wr_busy", d1_busy, 1'b1);
    @(negedge clk);
    res = 1'b0;
    #1;
    chk("rst_async_flags", {d1_rdy, d1_oe, d1_busy, d1_err}, 4'b0000);
    chk("rst_async_dout", d1_dout, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    @(posedge clk);
    @(negedge clk);
    res = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 8'h30, 8'h00);
    @(posedge clk); #1;
    chk("post_rst_accept", d1_busy, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    @(posedge clk); #1;
    chk("post_rst_rdy", d1_rdy, 1'b1);
    chk("post_rst_mem_kept", d1_dout, 8'h55);
    repeat (6) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/subleq_mem_responder.md
SUBLEQ_MEM_RESPONDER -- requirements
Module: subleq_mem_responder

Interface
REQ-001 Parameter ADR_W, default 8, address width; the memory depth SHALL be 2**ADR_W words.
REQ-002 Parameter DAT_W, default 8, data word width.
REQ-003 Parameter RD_LAT, default 1, legal range 1..4, read latency in clocks.
REQ-004 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-005 res  input  1  reset, asynchronous, active-low.
REQ-006 ram_ena  input  1  chip enable, active-high.
REQ-007 ram_ope  input  1  read request, active-low.
REQ-008 ram_ctl  input  1  write request, active-low.
REQ-009 adr  input  ADR_W  access address.
REQ-010 dat_in  input  DAT_W  write data.
REQ-011 ld_we  input  1  program-loader write strobe.
REQ-012 ld_adr  input  ADR_W  loader address.
REQ-013 ld_dat  input  DAT_W  loader data.
REQ-014 dat_out  output  DAT_W  read data.
REQ-015 dat_oe  output  1  read data is valid and driven.
REQ-016 ram_rdy  output  1  one-cycle access-complete pulse.
REQ-017 ram_busy  output  1  an access is in progress or awaiting release.
REQ-018 ram_err  output  1  one-cycle pulse on an illegal request.

Function
REQ-019 Request decode:
- read = ram_ena & !ram_ope & ram_ctl
- write = ram_ena & ram_ope & !ram_ctl
- illegal = ram_ena & !ram_ope & !ram_ctl
- all other combinations are idle.
REQ-020 FSM states SHALL be IDLE, RD_WAIT, WR, RESP and HOLD.
REQ-021 A request SHALL be accepted only in IDLE; adr and dat_in SHALL be latched at the accept edge (edge k).
REQ-022 Read path: IDLE->RD_WAIT; RD_WAIT counts RD_LAT-1 cycles (zero cycles when RD_LAT=1); then RESP.
- ram_rdy=1 and dat_out=mem[adr] SHALL hold in the cycle following edge k+RD_LAT.
REQ-023 Write path: IDLE->WR->RESP.
- mem[adr] SHALL be updated at edge k+1.
- ram_rdy=1 SHALL hold in the cycle following edge k+1.
REQ-024 RESP SHALL last exactly one cycle, then go to HOLD.
- HOLD SHALL return to IDLE on the first edge where the decode is idle (ram_ena=0 or ram_ope=ram_ctl=1).
- A level-held request SHALL therefore execute exactly once.
REQ-025 dat_out SHALL keep the last read value until the next read completes.
- dat_oe=1 from RESP through HOLD of a read only; otherwise dat_oe=0.
REQ-026 ram_busy=1 in every state except IDLE.
REQ-027 Illegal decode in IDLE: ram_err pulses one cycle, no memory access occurs, and the FSM enters HOLD.
REQ-028 Deasserting ram_ena or changing adr/dat_in mid-access SHALL NOT alter the latched access, which completes normally.
REQ-029 ld_we SHALL write ld_dat to mem[ld_adr] only in IDLE, and takes priority over a simultaneous request (request not accepted that edge); ld_we outside IDLE SHALL be ignored.
REQ-030 A read following a write to the same address SHALL return the new data.
REQ-031 Addresses SHALL be used unsigned and without wrap logic; every ADR_W value is valid.

Reset
REQ-032 On res=0, immediately and regardless of clk:
- state=IDLE, latency counter=0, dat_out=0;
- dat_oe=0, ram_rdy=0, ram_busy=0, ram_err=0.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 A write not yet committed when reset asserts SHALL be dropped.
REQ-035 After res rises, the first request SHALL be accepted on the first clk edge.

Structure
REQ-036 Shared package subleq_pkg SHALL hold:
- the FSM state type;
- the request-decode encodings;
- default ADR_W/DAT_W constants, shared with the control unit.
REQ-037 Storage SHALL be one sub-module, subleq_ram_array: synchronous write, registered read, single write port muxed between access and loader.

Verification
REQ-038 Loader: ld_we with ld_adr=0x10, ld_dat=0xA5; then read adr=0x10 (ram_ope=0, ram_ctl=1, ram_ena=1) with RD_LAT=1 -> ram_rdy one cycle after accept edge, dat_out=0xA5, dat_oe=1.
REQ-039 Held request: write adr=0x20, dat_in=0x3C, request held 6 cycles -> exactly one ram_rdy pulse; ram_busy=1 until release; read 0x20 returns 0x3C.
REQ-040 Latency: RD_LAT=3, read 0x10 -> ram_rdy exactly 3 cycles after the accept edge; adr changed to 0x11 at k+1 -> dat_out still 0xA5.
REQ-041 Illegal: ram_ope=0, ram_ctl=0, ram_ena=1 -> ram_err one-cycle pulse, no ram_rdy, memory unchanged; normal read accepted after release.
REQ-042 Reset mid-write: write adr=0x30, dat_in=0xFF, res=0 before edge k+1 -> all outputs 0 asynchronously; mem[0x30] keeps its prior value.
REQ-043 Collision: ld_we (0x40<-0x11) on the same edge as a read of 0x40 -> load wins; read accepted next edge returns 0x11.
